instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the multi-cycle MIPS datapath, directly upstream of the `control` decoder. It holds the PC and fetches one 32-bit instruction word per instruction from instruction memory over a req/ready handshake. It presents the opcode and funct fields, the remaining fields, and the PC+4 value to `control` and the datapath. It then computes the next PC from the `Jump`/`JumpSel`/`Branch` decisions that `control` registers one clock later.

## Interface

Parameters:

- `RESET_PC`, default 32'h0000_0000 — PC value loaded by reset; must be word-aligned.

Ports (the clock is named `clk` as in the rest of the codebase; the reset port is `resetn`):

- `clk` input 1 — single clock; all state changes on posedge.
- `resetn` input 1 — asynchronous, active-low reset.
- `imem_req` output 1 — fetch request to instruction memory.
- `imem_addr` output 32 — byte address of the fetch; equal to `pc`.
- `imem_ready` input 1 — memory has `imem_rdata` valid this cycle.
- `imem_rdata` input 32 — instruction word.
- `stall` input 1 — hold the current instruction in RESOLVE.
- `Jump`, `JumpSel`, `Branch` input 1 each — from `control`, sampled in RESOLVE.
- `zero` input 1 — ALU zero flag for the BNE compare, sampled in RESOLVE.
- `jr_target` input 32 — register-file rs value for JR.
- `opcode` output 6 — `instr[31:26]`.
- `funct` output 6 — `instr[5:0]`.
- `rs`, `rt`, `rd` output 5 each — `instr[25:21]`, `instr[20:16]`, `instr[15:11]`.
- `imm16` output 16 — `instr[15:0]`.
- `pc_plus4` output 32 — `pc + 4`, the JAL link value.
- `instr_valid` output 1 — high in DECODE and RESOLVE.
- `pc` output 32 — address of the current instruction.

## Operation

- Instruction register `instr` holds the fetched word; all field outputs are slices of `instr`.
- States: IDLE, FETCH, DECODE, RESOLVE.
  - IDLE: entered only by reset. Goes to FETCH on the next clock, unconditionally.
  - FETCH: `imem_req` = 1 and `imem_addr` = `pc`. On `imem_ready` = 1, capture `imem_rdata` into `instr` and go to DECODE. Otherwise remain in FETCH with the address held stable.
  - DECODE: one cycle. `control` registers its outputs from `opcode`/`funct` at the closing edge. Always goes to RESOLVE.
  - RESOLVE: if `stall` = 1, hold everything. If `stall` = 0, load `pc` with the next PC and go to FETCH.
- Next-PC priority, highest first:
  1. `Jump` & `JumpSel` → `{jr_target[31:2], 2'b00}` (JR).
  2. `Jump` & !`JumpSel` → `{pc_plus4[31:28], instr[25:0], 2'b00}` (J, JAL).
  3. `Branch` & !`zero` → `pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}` (BNE taken).
  4. Otherwise → `pc_plus4`.
- Arithmetic is 32-bit modulo 2^32; PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- `jr_target` bits [1:0] are discarded, so the PC is always word-aligned.
- `imem_req` is a Moore output of FETCH: 0 in every other state.

## Timing

- Reset values, asynchronous on `resetn` = 0:
  - state = IDLE
  - `pc` = `imem_addr` = `RESET_PC`
  - `pc_plus4` = `RESET_PC`+4
  - `instr` = 0, so `opcode` = `funct` = 0 and `control` decodes NOOP
  - `imem_req` = 0, `instr_valid` = 0
- First `imem_req` is high in the second cycle after `resetn` rises: IDLE then FETCH.
- Minimum 3 cycles per instruction when `imem_ready` arrives in the first FETCH cycle: FETCH, DECODE, RESOLVE.
- Each FETCH cycle with `imem_ready` = 0 adds one cycle; each RESOLVE cycle with `stall` = 1 adds one cycle.
- Handshake: the transfer occurs on the edge where `imem_req` & `imem_ready` are both 1. `imem_ready` outside FETCH is ignored. `imem_addr` is stable for as long as `imem_req` is high.
- `Jump`, `JumpSel`, `Branch`, `zero` and `jr_target` are sampled only in a RESOLVE cycle with `stall` = 0. Values in other cycles have no effect.
- Simultaneous `Jump` and `Branch`: `Jump` wins.
- `resetn` asserted mid-fetch drops `imem_req` immediately (asynchronously). A word returned afterwards is discarded.
- `instr` changes only on a FETCH capture, so the fields are stable throughout DECODE and RESOLVE.

## Test plan

- Reset with `RESET_PC`=0, `imem_ready` tied 1, memory returning ADD → `imem_req` 0 in the IDLE cycle, then 1 with addr 0. Instruction sequence at addr 0, 4, 8, every 3 cycles; `pc_plus4` = 4, 8, 12.
- `imem_ready` delayed 4 cycles at addr 8 → `imem_req` held 5 cycles with addr constant at 8. `instr` unchanged until capture; next fetch at 12.
- J at 0x0040_0010 with `instr[25:0]`=26'h010_0000 and `Jump`=1, `JumpSel`=0 → next `imem_addr` = 0x0040_0000.
- BNE at 0x20 with imm16=16'hFFFE:
  - `Branch`=1, `zero`=0 → next fetch at 0x1C.
  - Same instruction with `zero`=1 → next fetch at 0x24.
- JR with `jr_target`=0x0000_1237, `Jump`=1, `JumpSel`=1, plus `stall` high for 2 RESOLVE cycles → no fetch during the stall, then fetch at 0x1234. `Jump` and `Branch` both 1 → jump target taken.
- `resetn` pulsed low during FETCH of addr 0xC → `imem_req` falls with no clock edge. `pc` returns to `RESET_PC`, `opcode`/`funct` read 0, and fetching restarts at `RESET_PC`. PC 0xFFFF_FFFC non-branch → next fetch at 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch channel between the fetch stage and instruction memory.
// The fetch stage is the master: it raises a request and holds the address until the memory answers ready.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle MIPS fetch stage: holds the PC and the instruction register, fetches one word per
// instruction, and resolves the next PC from the jump/branch decisions that control registers.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  instr_fetch_if.master     imem,
  input  logic              stall,
  input  logic              Jump,
  input  logic              JumpSel,
  input  logic              Branch,
  input  logic              zero,
  input  logic [31:0]       jr_target,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [31:0]       pc_plus4,
  output logic              instr_valid,
  output logic [31:0]       pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    RESOLVE
  } state_t;

  state_t      state;
  logic [31:0] instr;
  logic        req_q;
  logic        valid_q;
  logic [31:0] next_pc;
  logic [31:0] branch_offset;
  logic        unused_jr_low;

  assign opcode      = instr[31:26];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign imm16       = instr[15:0];
  assign funct       = instr[5:0];
  assign pc_plus4    = pc + 32'd4;
  assign instr_valid = valid_q;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  // The low two bits of the JR target are dropped so the PC can never become misaligned.
  assign unused_jr_low = ^jr_target[1:0];

  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};

  // Jump beats branch; a JR uses the register value, J/JAL keep the PC+4 region bits.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump && JumpSel) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (Jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (Branch && !zero) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

  // The request and valid flags are registered so they follow the state exactly, and the
  // asynchronous reset drops the request without waiting for a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr   <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ready) begin
            instr   <= imem.imem_rdata;
            state   <= DECODE;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        DECODE: begin
          state <= RESOLVE;
        end
        RESOLVE: begin
          if (!stall) begin
            pc      <= next_pc;
            state   <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: walks a hand-written program through fetch, decode and resolve,
// including memory wait states, stalls, jumps, branches, a mid-fetch reset and PC wrap-around.
module tb_instr_fetch;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        Jump;
  logic        JumpSel;
  logic        Branch;
  logic        zero;
  logic [31:0] jr_target;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] pc;

  int compared   = 0;
  int mismatched = 0;

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .imem        (imem_bus),
    .stall       (stall),
    .Jump        (Jump),
    .JumpSel     (JumpSel),
    .Branch      (Branch),
    .zero        (zero),
    .jr_target   (jr_target),
    .opcode      (opcode),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm16       (imm16),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .pc          (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [31:0] rdata, input logic stl,
                               input logic j, input logic js, input logic br, input logic z,
                               input logic [31:0] jrt);
    imem_bus.imem_ready = ready;
    imem_bus.imem_rdata = rdata;
    stall     = stl;
    Jump      = j;
    JumpSel   = js;
    Branch    = br;
    zero      = z;
    jr_target = jrt;
  endtask

  // Entered in the first FETCH cycle of an instruction; leaves in the first FETCH cycle of the next.
  task automatic doInstr(input logic [31:0] pcExp, input logic [31:0] word, input logic [31:0] prevWord,
                         input int delay, input int stalls,
                         input logic j, input logic js, input logic br, input logic z,
                         input logic [31:0] jrt, input logic [31:0] nextExp);
    checkOutput("fetch_req", imem_bus.imem_req, 1);
    checkOutput("fetch_addr", imem_bus.imem_addr, pcExp);
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      stepCycle();
      checkOutput("wait_req", imem_bus.imem_req, 1);
      checkOutput("wait_addr", imem_bus.imem_addr, pcExp);
      checkOutput("wait_funct_held", funct, prevWord[5:0]);
    end
    applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("decode_valid", instr_valid, 1);
    checkOutput("decode_req", imem_bus.imem_req, 0);
    checkOutput("decode_opcode", opcode, word[31:26]);
    checkOutput("decode_funct", funct, word[5:0]);
    applyStimulus(1'b1, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("resolve_valid", instr_valid, 1);
    checkOutput("resolve_rs", rs, word[25:21]);
    checkOutput("resolve_rt", rt, word[20:16]);
    checkOutput("resolve_rd", rd, word[15:11]);
    checkOutput("resolve_imm16", imm16, word[15:0]);
    checkOutput("resolve_pc", pc, pcExp);
    checkOutput("resolve_pc_plus4", pc_plus4, pcExp + 32'd4);
    for (int i = 0; i < stalls; i++) begin
      applyStimulus(1'b1, 32'h1357_9BDF, 1'b1, j, js, br, z, jrt);
      stepCycle();
      checkOutput("stall_req", imem_bus.imem_req, 0);
      checkOutput("stall_valid", instr_valid, 1);
      checkOutput("stall_pc", pc, pcExp);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, j, js, br, z, jrt);
    stepCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("next_valid", instr_valid, 0);
    checkOutput("next_addr", imem_bus.imem_addr, nextExp);
  endtask

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b1, 32'h012A_4020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_addr", imem_bus.imem_addr, 32'h0);
    checkOutput("reset_pc_plus4", pc_plus4, 32'h4);
    checkOutput("reset_req", imem_bus.imem_req, 0);
    checkOutput("reset_valid", instr_valid, 0);
    checkOutput("reset_opcode", opcode, 6'h00);
    checkOutput("reset_funct", funct, 6'h00);

    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("idle_req", imem_bus.imem_req, 0);
    stepCycle();

    // Straight-line ADD, SUB, then ORI with four memory wait states.
    doInstr(32'h0000_0000, 32'h012A_4020, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0004);
    doInstr(32'h0000_0004, 32'h012A_4022, 32'h012A_4020, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0008);
    doInstr(32'h0000_0008, 32'h3528_1234, 32'h012A_4022, 4, 0, 0, 0, 0, 0, 32'h0, 32'h0000_000C);

    // J chain: 0xC -> 0x0040_0010 -> 0x0040_0000 -> 0x20.
    doInstr(32'h0000_000C, 32'h0810_0004, 32'h3528_1234, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0040_0010);
    doInstr(32'h0040_0010, 32'h0810_0000, 32'h0810_0004, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0040_0000);
    doInstr(32'h0040_0000, 32'h0800_0008, 32'h0810_0000, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0020);

    // BNE taken backwards, jump back, then BNE not taken.
    doInstr(32'h0000_0020, 32'h152A_FFFE, 32'h0800_0008, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0000_001C);
    doInstr(32'h0000_001C, 32'h0800_0008, 32'h152A_FFFE, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0000_0020);
    doInstr(32'h0000_0020, 32'h152A_FFFE, 32'h0800_0008, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0000_0024);

    // JR with a misaligned target, two stall cycles and Branch also asserted.
    doInstr(32'h0000_0024, 32'h0120_0008, 32'h152A_FFFE, 0, 2, 1, 1, 1, 0, 32'h0000_1237, 32'h0000_1234);
    doInstr(32'h0000_1234, 32'h0800_0003, 32'h0120_0008, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0000_000C);

    // Reset in the middle of a fetch at 0xC.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("midfetch_req", imem_bus.imem_req, 1);
    checkOutput("midfetch_addr", imem_bus.imem_addr, 32'h0000_000C);
    checkOutput("midfetch_opcode", opcode, 6'h02);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_req", imem_bus.imem_req, 0);
    checkOutput("async_reset_pc", pc, 32'h0);
    checkOutput("async_reset_opcode", opcode, 6'h00);
    checkOutput("async_reset_funct", funct, 6'h00);
    checkOutput("async_reset_valid", instr_valid, 0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    resetn = 1'b1;
    #1;
    checkOutput("restart_idle_req", imem_bus.imem_req, 0);
    stepCycle();
    checkOutput("restart_discard_opcode", opcode, 6'h00);
    checkOutput("restart_discard_funct", funct, 6'h00);

    // JR to the top word, then a plain instruction there wraps the PC to zero.
    doInstr(32'h0000_0000, 32'h0120_0008, 32'h0, 0, 0, 1, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    checkOutput("top_pc_plus4", pc_plus4, 32'h0000_0000);
    doInstr(32'hFFFF_FFFC, 32'h012A_4020, 32'h0120_0008, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
